pmu_ahb_poller: RTL and testbench

- AHB-lite master sitting directly upstream of the PMU AHB slave (base 32'h80100000).
- Periodically, or on trigger, sweeps a contiguous window of PMU counter registers with single non-pipelined reads.
- Emits each word on a valid/ready stream tagged with its register index, for trace/telemetry consumers.
- Backpressure on the stream stalls the sweep, so no data is dropped.

---
 rtl/pmu_poll_pkg.sv | 24 ++
 rtl/pmu_poll_timer.sv | 40 ++++
 rtl/pmu_ahb_poller.sv | 199 +++++++++++++++++++
 tb/tb_pmu_ahb_poller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_poll_pkg.sv
// Shared types and AHB-lite encodings for the PMU counter poller.
package pmu_poll_pkg;

  // Sweep sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_PUSH = 2'd3
  } state_t;

  // AHB-lite transfer types used by a single-read master
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // AHB-lite response codes
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Fixed transfer attributes: 32-bit single transfers
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/pmu_poll_timer.sv
// Reload down-counter that produces a one-cycle sweep request every
// period_i cycles while enabled. period_i == 0 disables periodic requests.
module pmu_poll_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_start_req
);

  logic                r_loaded;
  logic [PERIOD_W-1:0] r_cnt;
  logic                w_run;

  assign w_run       = i_enable && (i_period != '0);
  assign o_start_req = w_run && r_loaded && (r_cnt == PERIOD_W'(1));

  // Count down while running; reload on terminal count (or from an empty
  // count after period_i was zero), and take period_i right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_loaded <= 1'b0;
      r_cnt    <= '0;
    end else if (!r_loaded) begin
      r_loaded <= 1'b1;
      r_cnt    <= i_period;
    end else if (w_run) begin
      if ((r_cnt == PERIOD_W'(1)) || (r_cnt == '0)) begin
        r_cnt <= i_period;
      end else begin
        r_cnt <= r_cnt - PERIOD_W'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pmu_ahb_poller.sv
// AHB-lite master that sweeps a window of PMU counter registers with
// single non-pipelined reads and streams each word out with its index.
// Stream backpressure stalls the sweep so nothing is dropped.
module pmu_ahb_poller
  import pmu_poll_pkg::*;
#(
  parameter int unsigned            HADDR_WIDTH = 32,
  parameter int unsigned            HDATA_WIDTH = 32,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h8010_0000,
  parameter int unsigned            FIRST_REG   = 1,
  parameter int unsigned            N_READ      = 24,
  parameter int unsigned            PERIOD_W    = 16,
  parameter int unsigned            IDX_W       = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [PERIOD_W-1:0]    period_i,
  input  logic                   trigger_i,
  input  logic                   clr_i,
  output logic [HADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]             htrans_o,
  output logic                   hwrite_o,
  output logic [2:0]             hsize_o,
  output logic [2:0]             hburst_o,
  output logic [HDATA_WIDTH-1:0] hwdata_o,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
  input  logic [HDATA_WIDTH-1:0] hrdata_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [HDATA_WIDTH-1:0] m_data_o,
  output logic [IDX_W-1:0]       m_idx_o,
  output logic                   m_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   overrun_o
);

  // Byte address of the sweep's idx-th register
  function automatic logic [HADDR_WIDTH-1:0] reg_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ((HADDR_WIDTH'(FIRST_REG) + HADDR_WIDTH'(idx)) << 2);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_m_idx;
  logic [HDATA_WIDTH-1:0] r_data;
  logic                   r_last;
  logic                   r_err;
  logic                   r_overrun;

  logic w_start_req;
  logic w_req;
  logic w_busy;
  logic w_start;
  logic w_capture;
  logic w_idx_inc;
  logic w_err_set;
  logic w_done;
  logic w_overrun_set;

  pmu_poll_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_enable    (enable_i),
    .i_period    (period_i),
    .o_start_req (w_start_req)
  );

  // A timer tick and a trigger in the same cycle merge into one request;
  // any request arriving while a sweep runs is dropped and flagged.
  assign w_req         = w_start_req || trigger_i;
  assign w_busy        = (r_state != ST_IDLE);
  assign w_start       = (r_state == ST_IDLE) && w_req;
  assign w_overrun_set = w_busy && w_req;

  // Next-state and per-cycle control decode for the sweep sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_idx_inc   = 1'b0;
    w_err_set   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_ADDR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (hready_i) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (!hready_i) begin
          w_state_nxt = ST_DATA;
        end else if (hresp_i == HRESP_ERROR) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (!m_ready_i) begin
          w_state_nxt = ST_PUSH;
        end else if (r_last) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_inc   = 1'b1;
          w_state_nxt = ST_ADDR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Register index: cleared at every sweep start, advanced after each accepted word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx <= '0;
    end else if (w_start) begin
      r_idx <= '0;
    end else if (w_idx_inc) begin
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Stream holding register, loaded at the end of a good data phase
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_m_idx <= '0;
      r_last  <= 1'b0;
    end else if (w_capture) begin
      r_data  <= hrdata_i;
      r_m_idx <= r_idx;
      r_last  <= (r_idx == IDX_W'(N_READ - 1));
    end else begin
      r_data  <= r_data;
      r_m_idx <= r_m_idx;
      r_last  <= r_last;
    end
  end

  // Sticky status flags; a set event beats a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_err     <= w_err_set     ? 1'b1 : (clr_i ? 1'b0 : r_err);
      r_overrun <= w_overrun_set ? 1'b1 : (clr_i ? 1'b0 : r_overrun);
    end
  end

  // Address phase is driven only in ADDR; the bus is otherwise idle
  assign htrans_o  = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o   = (r_state == ST_ADDR) ? reg_addr(r_idx) : '0;
  assign hwrite_o  = 1'b0;
  assign hsize_o   = HSIZE_WORD;
  assign hburst_o  = HBURST_SINGLE;
  assign hwdata_o  = '0;

  assign m_valid_o = (r_state == ST_PUSH);
  assign m_data_o  = r_data;
  assign m_idx_o   = r_m_idx;
  assign m_last_o  = r_last;
  assign busy_o    = w_busy;
  assign done_o    = w_done;
  assign err_o     = r_err;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_pmu_ahb_poller.sv
// Directed bench for pmu_ahb_poller (N_READ=3) with a zero-wait AHB slave
// model returning 0x11 * word_index and an optional ERROR on one word.
module tb_pmu_ahb_poller;

  localparam logic [31:0] BASE = 32'h8010_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [15:0] period_i;
  logic        trigger_i;
  logic        clr_i;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic [1:0]  hresp_i;
  logic [31:0] hrdata_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic [5:0]  m_idx_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        overrun_o;

  pmu_ahb_poller #(
    .HADDR_WIDTH (32),
    .HDATA_WIDTH (32),
    .BASE_ADDR   (32'h8010_0000),
    .FIRST_REG   (1),
    .N_READ      (3),
    .PERIOD_W    (16),
    .IDX_W       (6)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enable_i  (enable_i),
    .period_i  (period_i),
    .trigger_i (trigger_i),
    .clr_i     (clr_i),
    .haddr_o   (haddr_o),
    .htrans_o  (htrans_o),
    .hwrite_o  (hwrite_o),
    .hsize_o   (hsize_o),
    .hburst_o  (hburst_o),
    .hwdata_o  (hwdata_o),
    .hready_i  (hready_i),
    .hresp_i   (hresp_i),
    .hrdata_i  (hrdata_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_idx_o   (m_idx_o),
    .m_last_o  (m_last_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Slave model: address phase sampled mid-cycle, data phase follows
  logic        s_ap;
  logic [31:0] s_ap_addr;
  logic        dp_valid = 1'b0;
  logic [31:0] dp_addr  = 32'h0;
  logic [31:0] dp_word;
  logic [31:0] err_word = 32'd63;

  assign dp_word  = (dp_addr - BASE) >> 2;
  assign hrdata_i = dp_valid ? (32'h11 * dp_word) : 32'h0;
  assign hresp_i  = (dp_valid && (dp_word == err_word)) ? 2'b01 : 2'b00;

  always @(negedge clk_i) begin
    s_ap      <= (htrans_o == 2'b10) && hready_i;
    s_ap_addr <= haddr_o;
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (hready_i) begin
      dp_valid <= s_ap;
      dp_addr  <= s_ap_addr;
    end
  end

  // Monitors: accepted stream words, done pulses, sweep starts, NONSEQ count
  logic [31:0] q_data[$];
  logic [5:0]  q_idx[$];
  int          q_start[$];
  int          done_cnt   = 0;
  int          nonseq_cnt = 0;

  always @(negedge clk_i) begin
    if (m_valid_o && m_ready_i) begin
      q_data.push_back(m_data_o);
      q_idx.push_back(m_idx_o);
    end
    if (done_o) done_cnt <= done_cnt + 1;
    if (htrans_o == 2'b10) nonseq_cnt <= nonseq_cnt + 1;
    if ((htrans_o == 2'b10) && (haddr_o == BASE + 32'h4)) q_start.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy_o; i++) tick();
    chk(tag, {63'd0, busy_o}, 64'd0);
  endtask

  task automatic clear_mon;
    q_data.delete();
    q_idx.delete();
    q_start.delete();
  endtask

  int d0;
  int n0;

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; period_i = 16'd0; trigger_i = 1'b0;
    clr_i = 1'b0; hready_i = 1'b1; m_ready_i = 1'b1;
    repeat (3) tick();
    chk("rst_htrans", {62'd0, htrans_o}, 64'd0);
    chk("rst_haddr", {32'd0, haddr_o}, 64'd0);
    chk("rst_valid", {63'd0, m_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_flags", {60'd0, done_o, err_o, overrun_o, m_last_o}, 64'd0);
    chk("rst_const", {29'd0, hwrite_o, hsize_o, hburst_o, hwdata_o}, {29'd0, 1'b0, 3'b010, 3'b000, 32'd0});
    rst_i = 1'b0;
    repeat (2) tick();

    // Basic triggered sweep, zero wait states, always ready
    clear_mon();
    d0 = done_cnt;
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;            // T+1
    chk("t1_nonseq0", {62'd0, htrans_o}, 64'd2);
    chk("t1_haddr0", {32'd0, haddr_o}, 64'h8010_0004);
    chk("t1_busy", {63'd0, busy_o}, 64'd1);
    tick();                                                 // T+2
    chk("t1_dphase_idle", {62'd0, htrans_o}, 64'd0);
    chk("t1_novalid", {63'd0, m_valid_o}, 64'd0);
    tick();                                                 // T+3
    chk("t1_valid0", {63'd0, m_valid_o}, 64'd1);
    chk("t1_word0", {26'd0, m_idx_o, m_data_o}, {26'd0, 6'd0, 32'h11});
    chk("t1_last0", {62'd0, m_last_o, done_o}, 64'd0);
    tick();                                                 // T+4
    chk("t1_haddr1", {30'd0, htrans_o, haddr_o}, {30'd0, 2'b10, 32'h8010_0008});
    tick(); tick();                                         // T+6
    chk("t1_word1", {26'd0, m_idx_o, m_data_o}, {26'd0, 6'd1, 32'h22});
    tick();                                                 // T+7
    chk("t1_haddr2", {30'd0, htrans_o, haddr_o}, {30'd0, 2'b10, 32'h8010_000C});
    tick(); tick();                                         // T+9
    chk("t1_word2", {26'd0, m_idx_o, m_data_o}, {26'd0, 6'd2, 32'h33});
    chk("t1_done_last", {62'd0, done_o, m_last_o}, 64'd3);
    tick();                                                 // T+10
    chk("t1_after", {61'd0, busy_o, done_o, m_valid_o}, 64'd0);
    chk("t1_nwords", q_data.size(), 64'd3);
    chk("t1_q", {q_idx[0], q_idx[1], q_idx[2], q_data[0][7:0], q_data[1][7:0], q_data[2][7:0]},
        {6'd0, 6'd1, 6'd2, 8'h11, 8'h22, 8'h33});
    chk("t1_done_cnt", done_cnt - d0, 64'd1);

    // Backpressure at idx 1: word held, no new address phase
    clear_mon();
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;             // T+1
    repeat (4) tick();                                      // T+5
    m_ready_i = 1'b0;
    tick();                                                 // T+6
    n0 = nonseq_cnt;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {24'd0, m_valid_o, m_idx_o, m_data_o, htrans_o}, {24'd0, 1'b1, 6'd1, 32'h22, 2'b00});
      if (i < 9) tick();
    end
    chk("bp_no_nonseq", nonseq_cnt - n0, 64'd0);
    m_ready_i = 1'b1;
    tick();
    chk("bp_resume", {30'd0, htrans_o, haddr_o}, {30'd0, 2'b10, 32'h8010_000C});
    wait_idle("bp_idle");
    chk("bp_nwords", q_data.size(), 64'd3);
    chk("bp_q2", {26'd0, q_idx[2], q_data[2]}, {26'd0, 6'd2, 32'h33});

    // Bus error on idx 1: abort, no word, no done, sticky err, clear
    clear_mon();
    d0 = done_cnt;
    err_word = 32'd2;
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;             // T+1
    repeat (5) tick();                                      // T+6
    chk("err_set", {62'd0, err_o, busy_o}, 64'd2);
    chk("err_novalid", {63'd0, m_valid_o}, 64'd0);
    repeat (5) tick();
    chk("err_nwords", q_data.size(), 64'd1);
    chk("err_nodone", done_cnt - d0, 64'd0);
    chk("err_sticky", {63'd0, err_o}, 64'd1);
    err_word = 32'd63;
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("err_clr", {63'd0, err_o}, 64'd0);

    // Request while busy sets overrun even with a same-cycle clear
    clear_mon();
    d0 = done_cnt;
    trigger_i = 1'b1; tick();                               // T+1, busy
    clr_i = 1'b1; tick(); trigger_i = 1'b0; clr_i = 1'b0;
    chk("ovr_set_wins", {63'd0, overrun_o}, 64'd1);
    wait_idle("ovr_idle");
    chk("ovr_sweep_done", done_cnt - d0, 64'd1);
    chk("ovr_nwords", q_data.size(), 64'd3);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("ovr_clr", {63'd0, overrun_o}, 64'd0);

    // Periodic sweeps every 20 cycles, no overrun, then freeze
    clear_mon();
    enable_i = 1'b1; period_i = 16'd20;
    repeat (70) tick();
    enable_i = 1'b0;
    wait_idle("per_idle");
    chk("per_nstarts", q_start.size(), 64'd3);
    if (q_start.size() >= 3) begin
      chk("per_gap1", q_start[1] - q_start[0], 64'd20);
      chk("per_gap2", q_start[2] - q_start[1], 64'd20);
    end
    chk("per_no_overrun", {63'd0, overrun_o}, 64'd0);
    chk("per_nwords", q_data.size(), 64'd9);
    n0 = q_start.size();
    repeat (40) tick();
    chk("per_frozen", q_start.size() - n0, 64'd0);

    // Short period: overrun flagged, sweeps still complete
    clear_mon();
    d0 = done_cnt;
    period_i = 16'd4; enable_i = 1'b1;
    repeat (40) tick();
    enable_i = 1'b0; period_i = 16'd0;
    wait_idle("ovp_idle");
    chk("ovp_overrun", {63'd0, overrun_o}, 64'd1);
    chk("ovp_done_min", (done_cnt - d0) >= 2, 64'd1);
    chk("ovp_words", q_data.size(), 64'(3 * (done_cnt - d0)));
    if (q_data.size() >= 3)
      chk("ovp_first", {q_idx[0], q_idx[1], q_idx[2], q_data[2][7:0]}, {6'd0, 6'd1, 6'd2, 8'h33});
    clr_i = 1'b1; tick(); clr_i = 1'b0;

    // Asynchronous reset in DATA, then a clean sweep
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;             // T+1
    tick();                                                 // T+2 DATA
    chk("ar_in_data", {62'd0, htrans_o}, 64'd0);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_async", {61'd0, busy_o, m_valid_o, htrans_o == 2'b10}, 64'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (2) tick();
    clear_mon();
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;
    chk("ar_restart", {30'd0, htrans_o, haddr_o}, {30'd0, 2'b10, 32'h8010_0004});
    wait_idle("ar_idle");
    chk("ar_nwords", q_data.size(), 64'd3);
    if (q_data.size() >= 3)
      chk("ar_q", {q_idx[0], q_idx[1], q_idx[2], q_data[0][7:0], q_data[2][7:0]},
          {6'd0, 6'd1, 6'd2, 8'h11, 8'h33});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
